mul8_seq_ctrl: RTL

- Sequencing controller that computes an unsigned 8x8 product using one shared combinational 4x4 multiplier (multiplier4bit) over four cycles, one nibble partial product per cycle.
- Sits between an upstream operand source and a downstream consumer, with valid/ready handshakes on both sides.
- Optionally runs as a 16-bit multiply-accumulate unit for filter and dot-product use.

---
 rtl/mul8_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier / 16-bit MAC built around one shared 4x4 multiplier.
// Optional sticky overflow flag and port: define MUL8_SEQ_OVF_EN.

module multiplier4bit (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] prod
);
  assign prod = {4'b0000, x} * {4'b0000, y};
endmodule

module mul8_seq_ctrl #(
  parameter bit ACCUMULATE = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        clear,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p,
  output logic        busy
`ifdef MUL8_SEQ_OVF_EN
  ,
  output logic        ovf
`endif
);

  typedef enum logic [2:0] {IDLE, PP0, PP1, PP2, PP3, DONE} state_t;

  state_t      state, next_state;
  logic [7:0]  a_reg, b_reg;
  logic [15:0] acc;
  logic [3:0]  mul_x, mul_y;
  logic [7:0]  pp;
  logic [15:0] addend;
  logic [16:0] sum;

  multiplier4bit u_mul (
    .x    (mul_x),
    .y    (mul_y),
    .prod (pp)
  );

  // The state selects which operand nibbles feed the shared multiplier and how far to shift.
  always_comb begin
    mul_x  = a_reg[3:0];
    mul_y  = b_reg[3:0];
    addend = 16'h0000;
    case (state)
      PP0: addend = {8'h00, pp};
      PP1: begin
        mul_x  = a_reg[7:4];
        addend = {4'h0, pp, 4'h0};
      end
      PP2: begin
        mul_y  = b_reg[7:4];
        addend = {4'h0, pp, 4'h0};
      end
      PP3: begin
        mul_x  = a_reg[7:4];
        mul_y  = b_reg[7:4];
        addend = {pp, 8'h00};
      end
      default: addend = 16'h0000;
    endcase
  end

  assign sum = {1'b0, acc} + {1'b0, addend};

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = PP0;
      PP0:     next_state = PP1;
      PP1:     next_state = PP2;
      PP2:     next_state = PP3;
      PP3:     next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // A clear coinciding with an accept zeroes the accumulator and the transaction still proceeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg <= 8'h00;
      b_reg <= 8'h00;
      acc   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            if ((ACCUMULATE == 1'b0) || clear) acc <= 16'h0000;
          end else if (clear) begin
            acc <= 16'h0000;
          end
        end
        PP0, PP1, PP2, PP3: acc <= sum[15:0];
        default: ;
      endcase
    end
  end

`ifdef MUL8_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      case (state)
        IDLE:               if (clear) ovf_q <= 1'b0;
        PP0, PP1, PP2, PP3: if (sum[16]) ovf_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign ovf = ovf_q;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == PP0) || (state == PP1) || (state == PP2) || (state == PP3);
  assign p         = acc;

endmodule
